vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
Parameters (name, default, meaning):
REQ-001 H_ACTIVE, 640: visible pixels per line.
REQ-002 H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal front porch, sync and back porch widths in pixels.
REQ-003 V_ACTIVE, 480; V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical equivalents, in lines.

Ports (name, direction, width, meaning):
REQ-004 i_clk  in  1  single system clock; all logic on its rising edge.
REQ-005 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 i_pix_en  in  1  pixel-clock enable; counters advance only on cycles where it is 1.
REQ-007 o_H_Cont  out  13  horizontal position, 0..H_TOTAL-1; values 0..H_ACTIVE-1 are visible. This output feeds the sprite blocks' i_H_Cont.
REQ-008 o_V_Cont  out  13  vertical position, 0..V_TOTAL-1; values 0..V_ACTIVE-1 are visible. This output feeds the sprite blocks' i_V_Cont.
REQ-009 o_hsync_n  out  1  horizontal sync, active-low.
REQ-010 o_vsync_n  out  1  vertical sync, active-low.
REQ-011 o_blank_n  out  1  1 when both counters are in the active region.
REQ-012 o_line_start  out  1  one-pixel pulse when o_H_Cont==0.
REQ-013 o_frame_start  out  1  one-pixel pulse when o_H_Cont==0 and o_V_Cont==0.

Function
REQ-014 H_TOTAL SHALL equal H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL SHALL equal the vertical sum (525).
REQ-015 Region order per line/frame SHALL be: active, front porch, sync, back porch.
REQ-016 On an i_pix_en cycle, o_H_Cont SHALL increment; at H_TOTAL-1 it SHALL wrap to 0.
REQ-017 o_V_Cont SHALL increment only on the cycle o_H_Cont wraps; at V_TOTAL-1 it SHALL wrap to 0, simultaneously with the H wrap.
REQ-018 With i_pix_en=0, all outputs SHALL hold, including the pulse outputs.
REQ-019 o_hsync_n SHALL be 0 exactly for o_H_Cont in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1] (656..751).
REQ-020 o_vsync_n SHALL be 0 exactly for o_V_Cont in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1] (490..491).
REQ-021 All sync, blank and pulse outputs SHALL be registered and SHALL be decoded from next-state counter values, so they align with the counter values on the same cycle (zero skew, no combinational path to outputs).
REQ-022 Counters SHALL be 13 bits; comparisons SHALL be unsigned; the parameter sums SHALL fit in 13 bits (static check).
REQ-023 o_line_start and o_frame_start SHALL be high for exactly one i_pix_en period (they are qualified by hold per REQ-018).

Reset
REQ-024 While i_rst_n=0: o_H_Cont=0, o_V_Cont=0, o_hsync_n=1, o_vsync_n=1, o_blank_n=1, o_line_start=1, o_frame_start=1 (position 0,0 state).
REQ-025 A reset asserted mid-frame SHALL take effect immediately (asynchronously); after release, the first i_pix_en cycle SHALL advance to (1,0).
REQ-026 Reset release SHALL be synchronised internally (2-flop release synchroniser) before the counters use it.

Structure
REQ-027 The timing parameter defaults and the 13-bit coordinate width constant SHALL live in a shared VGA package so that the sprite blocks use the same width.
REQ-028 One sub-module, vga_axis_counter (parameterised active/front/sync/back, carry-in, carry-out, sync and active decode), SHALL be instantiated twice: horizontal, and vertical with carry-in = horizontal carry-out.

Verification
REQ-029 Reset, then i_pix_en=1 constant -> o_H_Cont sequence 0,1,...,799,0; o_V_Cont 0->1 on the wrap cycle.
REQ-030 Run one full frame -> o_hsync_n low for 96 pixels per line (656..751); o_vsync_n low for lines 490..491 only; exactly 420000 cycles, i.e. 800x525.
REQ-031 At (799,524) with an i_pix_en pulse -> next state is (0,0), o_frame_start=1 for one enable period, o_blank_n=1.
REQ-032 i_pix_en toggling 1,0,1,0 -> counters advance every other clock; o_line_start stays high across the held (0) cycle and drops after the next enable.
REQ-033 Assert i_rst_n=0 at (300,200) asynchronously, between clock edges -> outputs go to the REQ-024 values before the next edge; after release, counting resumes from 0.
REQ-034 o_blank_n check -> equals 1 iff o_H_Cont<640 and o_V_Cont<480 over a full frame (307200 cycles high).

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - shared VGA coordinate width and 640x480@60 timing defaults
//
// Purpose: single source for the coordinate width and default timing, so the
// timing generator and the sprite blocks agree on position encoding.
// Ports: none (package).

package vga_timing_gen_pkg;

    localparam int COORD_W = 13;

    typedef logic [COORD_W-1:0] coord_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;

    // A total is representable when the last position TOTAL-1 fits in COORD_W bits.
    function automatic bit fits_coord(input int total);
        return (total > 0) && (total <= (1 << COORD_W));
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: position counter with sync/active decode
//
// Purpose: counts positions 0..TOTAL-1 (active, front porch, sync, back porch)
// advancing on i_carry, and decodes sync from the next-state count so the
// registered sync lines up with the registered count.
// Ports:
//   i_clk       clock
//   i_rst_n     asynchronous active-low reset (already release-synchronised)
//   i_carry     advance enable for this axis
//   o_carry     i_carry while at the last position (wrap this cycle)
//   o_cnt       registered position
//   o_sync_n    registered active-low sync
//   o_active_d  next-state "inside active region" decode (combinational)

module vga_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FRONT  = 16,
    parameter int SYNC   = 96,
    parameter int BACK   = 48
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_carry,
    output logic               o_carry,
    output logic [COORD_W-1:0] o_cnt,
    output logic               o_sync_n,
    output logic               o_active_d
);

    localparam int     TOTAL      = ACTIVE + FRONT + SYNC + BACK;
    localparam coord_t LAST       = coord_t'(TOTAL - 1);
    localparam coord_t SYNC_FIRST = coord_t'(ACTIVE + FRONT);
    localparam coord_t SYNC_LAST  = coord_t'(ACTIVE + FRONT + SYNC - 1);
    localparam coord_t ACT_END    = coord_t'(ACTIVE);

    coord_t cnt_q, cnt_d;
    logic   sync_n_q, sync_n_d;
    logic   wrap;

    always_comb begin
        wrap    = (cnt_q == LAST);
        o_carry = i_carry & wrap;
        cnt_d   = cnt_q;
        if (i_carry) begin
            cnt_d = wrap ? '0 : cnt_q + coord_t'(1);
        end
        sync_n_d   = !((cnt_d >= SYNC_FIRST) && (cnt_d <= SYNC_LAST));
        o_active_d = (cnt_d < ACT_END);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q    <= '0;
            sync_n_q <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            sync_n_q <= sync_n_d;
        end
    end

    assign o_cnt    = cnt_q;
    assign o_sync_n = sync_n_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator (H/V counters, syncs, blank, pulses)
//
// Purpose: generates raster position and sync/blank/start strobes. Every
// output is a flop whose next value is decoded from next-state counters, so
// all outputs change together with the position they describe.
// Ports:
//   i_clk          clock
//   i_rst_n        asynchronous active-low reset; release is synchronised
//   i_pix_en       pixel enable; nothing changes on cycles where it is 0
//   o_H_Cont       horizontal position 0..H_TOTAL-1
//   o_V_Cont       vertical position 0..V_TOTAL-1
//   o_hsync_n      horizontal sync, active-low
//   o_vsync_n      vertical sync, active-low
//   o_blank_n      1 inside the visible area
//   o_line_start   high while o_H_Cont == 0
//   o_frame_start  high while o_H_Cont == 0 and o_V_Cont == 0

module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_pix_en,
    output logic [COORD_W-1:0] o_H_Cont,
    output logic [COORD_W-1:0] o_V_Cont,
    output logic               o_hsync_n,
    output logic               o_vsync_n,
    output logic               o_blank_n,
    output logic               o_line_start,
    output logic               o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    if (!fits_coord(H_TOTAL) || !fits_coord(V_TOTAL)) begin : g_bad_timing
        $fatal(1, "vga_timing_gen: timing totals exceed coordinate width");
    end

    // Reset asserts immediately but releases two clocks later, so every
    // counter flop leaves reset on the same edge.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    logic h_carry, v_carry;
    logic h_active_d, v_active_d;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_axis (
        .i_clk      (i_clk),
        .i_rst_n    (rst_n_int),
        .i_carry    (i_pix_en),
        .o_carry    (h_carry),
        .o_cnt      (o_H_Cont),
        .o_sync_n   (o_hsync_n),
        .o_active_d (h_active_d)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_axis (
        .i_clk      (i_clk),
        .i_rst_n    (rst_n_int),
        .i_carry    (h_carry),
        .o_carry    (v_carry),
        .o_cnt      (o_V_Cont),
        .o_sync_n   (o_vsync_n),
        .o_active_d (v_active_d)
    );

    logic blank_n_q, blank_n_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    // A wrap carry means the next position is H==0 (or H==0,V==0); without
    // an enable the strobes keep their value, matching the held counters.
    always_comb begin
        blank_n_d     = h_active_d & v_active_d;
        line_start_d  = i_pix_en ? h_carry : line_start_q;
        frame_start_d = i_pix_en ? v_carry : frame_start_q;
    end

    always_ff @(posedge i_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            blank_n_q     <= 1'b1;
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
        end else begin
            blank_n_q     <= blank_n_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign o_blank_n     = blank_n_q;
    assign o_line_start  = line_start_q;
    assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen

module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_en;

    logic [12:0] d_h, d_v;
    logic        d_hs, d_vs, d_blank, d_ls, d_fs;
    logic [12:0] s_h, s_v;
    logic        s_hs, s_vs, s_blank, s_ls, s_fs;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pix_en      (pix_en),
        .o_H_Cont      (d_h),
        .o_V_Cont      (d_v),
        .o_hsync_n     (d_hs),
        .o_vsync_n     (d_vs),
        .o_blank_n     (d_blank),
        .o_line_start  (d_ls),
        .o_frame_start (d_fs)
    );

    // Small raster: H 10/2/3/2 (17 total), V 6/1/2/1 (10 total), 170 cycles per frame.
    vga_timing_gen #(
        .H_ACTIVE (10), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
        .V_ACTIVE (6),  .V_FRONT (1), .V_SYNC (2), .V_BACK (1)
    ) u_small (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pix_en      (pix_en),
        .o_H_Cont      (s_h),
        .o_V_Cont      (s_v),
        .o_hsync_n     (s_hs),
        .o_vsync_n     (s_vs),
        .o_blank_n     (s_blank),
        .o_line_start  (s_ls),
        .o_frame_start (s_fs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_small_reset(input string tag);
        chk({tag, " s_h"}, s_h, 0);
        chk({tag, " s_v"}, s_v, 0);
        chk({tag, " s_hs"}, s_hs, 1);
        chk({tag, " s_vs"}, s_vs, 1);
        chk({tag, " s_blank"}, s_blank, 1);
        chk({tag, " s_ls"}, s_ls, 1);
        chk({tag, " s_fs"}, s_fs, 1);
    endtask

    initial begin
        int hs_low;
        int vs_low;
        int blank_hi;
        int ls_cnt;
        int fs_cnt;
        int hx;
        int vy;

        // Reset state
        rst_n  = 1'b0;
        pix_en = 1'b0;
        repeat (2) tick();
        chk("rst d_h", d_h, 0);
        chk("rst d_v", d_v, 0);
        chk("rst d_hs", d_hs, 1);
        chk("rst d_vs", d_vs, 1);
        chk("rst d_blank", d_blank, 1);
        chk("rst d_ls", d_ls, 1);
        chk("rst d_fs", d_fs, 1);
        chk_small_reset("rst");

        // Release passes the synchroniser; with no enable the position stays (0,0)
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post-release d_h", d_h, 0);
        chk("post-release d_ls", d_ls, 1);

        // First line of the default raster: 1..799, syncs and blank per pixel
        pix_en   = 1'b1;
        hs_low   = 0;
        blank_hi = 1;
        for (int i = 1; i < 800; i++) begin
            tick();
            chk("line d_h", d_h, i);
            chk("line d_v", d_v, 0);
            chk("line d_hs", d_hs, (i >= 656 && i <= 751) ? 0 : 1);
            chk("line d_blank", d_blank, (i < 640) ? 1 : 0);
            chk("line d_ls", d_ls, 0);
            chk("line d_fs", d_fs, 0);
            if (!d_hs) hs_low++;
            if (d_blank) blank_hi++;
        end
        chk("hsync low pixels", hs_low, 96);
        chk("blank high pixels", blank_hi, 640);

        // Line wrap: H back to 0, V steps to 1 on the same cycle
        tick();
        chk("wrap d_h", d_h, 0);
        chk("wrap d_v", d_v, 1);
        chk("wrap d_ls", d_ls, 1);
        chk("wrap d_fs", d_fs, 0);
        chk("wrap d_blank", d_blank, 1);
        chk("wrap d_hs", d_hs, 1);

        // Enable toggling 0,1,0,1: counters and pulse hold on disabled cycles
        pix_en = 1'b0;
        tick();
        chk("hold d_h", d_h, 0);
        chk("hold d_ls", d_ls, 1);
        pix_en = 1'b1;
        tick();
        chk("step1 d_h", d_h, 1);
        chk("step1 d_ls", d_ls, 0);
        pix_en = 1'b0;
        tick();
        chk("hold2 d_h", d_h, 1);
        pix_en = 1'b1;
        tick();
        chk("step2 d_h", d_h, 2);
        chk("step2 d_v", d_v, 1);

        // Restart both instances, then walk the small raster to (5,3)
        pix_en = 1'b0;
        rst_n  = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk_small_reset("restart");
        pix_en = 1'b1;
        repeat (56) tick();
        chk("mid s_h", s_h, 5);
        chk("mid s_v", s_v, 3);
        chk("mid s_blank", s_blank, 1);

        // Asynchronous reset between edges takes effect before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        chk_small_reset("async");
        chk("async d_h", d_h, 0);
        pix_en = 1'b0;
        rst_n  = 1'b1;
        repeat (3) tick();
        chk_small_reset("async-release");

        // One full small frame against a reference position model
        pix_en   = 1'b1;
        hx       = 0;
        vy       = 0;
        hs_low   = 0;
        vs_low   = 0;
        blank_hi = 0;
        ls_cnt   = 0;
        fs_cnt   = 0;
        for (int n = 1; n <= 170; n++) begin
            tick();
            if (hx == 16) begin
                hx = 0;
                vy = (vy == 9) ? 0 : vy + 1;
            end else begin
                hx = hx + 1;
            end
            chk("frame s_h", s_h, hx);
            chk("frame s_v", s_v, vy);
            chk("frame s_hs", s_hs, (hx >= 12 && hx <= 14) ? 0 : 1);
            chk("frame s_vs", s_vs, (vy >= 7 && vy <= 8) ? 0 : 1);
            chk("frame s_blank", s_blank, (hx < 10 && vy < 6) ? 1 : 0);
            chk("frame s_ls", s_ls, (hx == 0) ? 1 : 0);
            chk("frame s_fs", s_fs, (hx == 0 && vy == 0) ? 1 : 0);
            if (!s_hs) hs_low++;
            if (!s_vs) vs_low++;
            if (s_blank) blank_hi++;
            if (s_ls) ls_cnt++;
            if (s_fs) fs_cnt++;
        end
        chk("frame hsync low", hs_low, 30);
        chk("frame vsync low", vs_low, 34);
        chk("frame blank high", blank_hi, 60);
        chk("frame line pulses", ls_cnt, 10);
        chk("frame frame pulses", fs_cnt, 1);
        chk("frame end s_h", s_h, 0);
        chk("frame end s_v", s_v, 0);
        chk("frame end s_fs", s_fs, 1);
        chk("frame end s_blank", s_blank, 1);

        // Frame pulse holds through a disabled cycle, drops after next enable
        pix_en = 1'b0;
        tick();
        chk("fs hold", s_fs, 1);
        chk("fs hold s_h", s_h, 0);
        pix_en = 1'b1;
        tick();
        chk("fs drop", s_fs, 0);
        chk("fs drop s_h", s_h, 1);
        chk("fs drop s_v", s_v, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
